// File: rtl/mul_add_arbiter.sv
// Round-robin arbiter that shares one pipelined mul_add unit among NUM_REQ requesters.
// Issue is credit-gated so the tagged results always fit in the response FIFO.
module mul_add_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  input  logic [NUM_REQ*WIDTH-1:0] req_z,
  output logic [WIDTH-1:0]         unit_x,
  output logic [WIDTH-1:0]         unit_y,
  output logic [WIDTH-1:0]         unit_z,
  input  logic [WIDTH-1:0]         unit_out,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0] x_arr [NUM_REQ];
  logic [WIDTH-1:0] y_arr [NUM_REQ];
  logic [WIDTH-1:0] z_arr [NUM_REQ];

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  cand;
  logic [CNT_W-1:0] pending_cnt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             credit;
  logic             issue;
  logic             push;
  logic             pop;

  logic             tag_valid [LATENCY];
  logic [ID_W-1:0]  tag_id    [LATENCY];

  logic [WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ID_W-1:0]  mem_id   [FIFO_DEPTH];

  // Credit depends only on registered state, so req_ready never sees resp_ready.
  assign credit = (pending_cnt < DEPTH_CNT);
  assign issue  = credit && !rst && req_valid[grant];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign x_arr[gi]     = req_x[gi*WIDTH +: WIDTH];
      assign y_arr[gi]     = req_y[gi*WIDTH +: WIDTH];
      assign z_arr[gi]     = req_z[gi*WIDTH +: WIDTH];
      assign req_ready[gi] = credit && !rst && (grant == ID_W'(gi));
    end
  endgenerate

  // Scan downward so the smallest offset from rr_ptr wins; idle grant stays at rr_ptr.
  always_comb begin
    grant = rr_ptr;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant = cand;
      end
    end
  end

  assign unit_x = issue ? x_arr[grant] : '0;
  assign unit_y = issue ? y_arr[grant] : '0;
  assign unit_z = issue ? z_arr[grant] : '0;

  always_ff @(posedge clk) begin
    tag_id[0] <= grant;
    for (int s = 1; s < LATENCY; s++) begin
      tag_id[s] <= tag_id[s-1];
    end
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_valid[s] <= 1'b0;
      end
    end else begin
      tag_valid[0] <= issue;
      for (int s = 1; s < LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
      end
    end
  end

  assign push = tag_valid[LATENCY-1];
  assign pop  = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= unit_out;
      mem_id[wr_ptr]   <= tag_id[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      pending_cnt <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= (grant == LAST_ID) ? '0 : grant + 1'b1;
      end
      pending_cnt <= pending_cnt + CNT_W'(issue) - CNT_W'(pop);
      fifo_cnt    <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  assign resp_valid = !rst && (fifo_cnt != '0);
  assign resp_id    = mem_id[rd_ptr];
  assign resp_data  = mem_data[rd_ptr];
  assign busy       = !rst && (pending_cnt != '0);

  // Every stored or in-flight result holds a credit, so a push never finds the FIFO full.
  assert property (@(posedge clk) disable iff (rst) push |-> (fifo_cnt < DEPTH_CNT || pop));

endmodule

// File: tb/tb_mul_add_arbiter.sv
// Bench for mul_add_arbiter: random traffic against a queue-based transaction model
// plus a behavioural LATENCY-deep mul_add unit.
`timescale 1ns/1ps
module tb_mul_add_arbiter;
  localparam int N = 4, W = 32, LAT = 3, DEPTH = 8, IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   x_arr [N];
  logic [W-1:0]   y_arr [N];
  logic [W-1:0]   z_arr [N];
  logic [N*W-1:0] req_x, req_y, req_z;
  logic [W-1:0]   unit_x, unit_y, unit_z, unit_out;
  logic           resp_valid, busy;
  logic           resp_ready = 1'b1;
  logic [IDW-1:0] resp_id;
  logic [W-1:0]   resp_data;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_x[gi*W +: W] = x_arr[gi];
    assign req_y[gi*W +: W] = y_arr[gi];
    assign req_z[gi*W +: W] = z_arr[gi];
  end

  logic [W-1:0] unit_pipe [LAT];
  always_ff @(posedge clk) begin
    unit_pipe[0] <= unit_x * unit_y + unit_z;
    for (int s = 1; s < LAT; s++) unit_pipe[s] <= unit_pipe[s-1];
  end
  assign unit_out = unit_pipe[LAT-1];

  mul_add_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .unit_x(unit_x), .unit_y(unit_y), .unit_z(unit_z), .unit_out(unit_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .busy(busy)
  );

  // Transaction model: queue of accepted ops, each visible from LAT+1 cycles after issue.
  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    int             vis;
  } op_t;

  op_t q[$];
  int  rr = 0, cyc = 0, checks = 0, fails = 0;
  int  e_grant;
  logic [N-1:0]   e_ready;
  logic           e_rv, e_busy, e_issue, e_pop;
  logic [IDW-1:0] e_id;
  logic [W-1:0]   e_data, e_ux, e_uy, e_uz;

  task automatic model_expect();
    int g;
    g = rr;
    for (int k = N - 1; k >= 0; k--) if (req_valid[(rr + k) % N]) g = (rr + k) % N;
    e_grant = g; e_ready = '0; e_rv = 0; e_busy = 0; e_issue = 0; e_pop = 0;
    e_id = '0; e_data = '0; e_ux = '0; e_uy = '0; e_uz = '0;
    if (!rst) begin
      if (q.size() < DEPTH) e_ready[g] = 1'b1;
      e_issue = e_ready[g] && req_valid[g];
      if (e_issue) begin e_ux = x_arr[g]; e_uy = y_arr[g]; e_uz = z_arr[g]; end
      e_rv = (q.size() > 0) && (q[0].vis <= cyc);
      if (e_rv) begin e_id = q[0].id; e_data = q[0].data; end
      e_pop  = e_rv && resp_ready;
      e_busy = (q.size() != 0);
    end
  endtask

  task automatic model_clock();
    logic [W-1:0] d;
    d = x_arr[e_grant] * y_arr[e_grant] + z_arr[e_grant];
    @(posedge clk);
    if (rst) begin
      q.delete();
      rr = 0;
    end else begin
      if (e_pop) begin
        $display("cyc=%0d pop id=%0d data=%h", cyc, e_id, e_data);
        void'(q.pop_front());
      end
      if (e_issue) begin
        q.push_back('{IDW'(e_grant), d, cyc + LAT + 1});
        rr = (e_grant + 1) % N;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      x_arr[i] = $urandom; y_arr[i] = $urandom; z_arr[i] = $urandom;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      set_idle(); rst = 1'b1; req_valid = 4'b1111;
      model_expect(); #1;
      checks++; if ({req_ready, resp_valid, busy} !== 6'b0) begin fails++;
        $display("FAIL reset_outputs cyc=%0d got ready=%b rv=%b busy=%b exp all 0", cyc, req_ready, resp_valid, busy); end
      checks++; if ({unit_x, unit_y, unit_z} !== {e_ux, e_uy, e_uz}) begin fails++;
        $display("FAIL reset_unit cyc=%0d got=%h %h %h exp=%h %h %h", cyc, unit_x, unit_y, unit_z, e_ux, e_uy, e_uz); end
      model_clock();
    end
  endtask

  task automatic test_single();
    int first_c = -1;
    for (int c = 0; c < 10; c++) begin
      set_idle();
      if (c == 0) begin req_valid = 4'b0100; x_arr[2] = 3; y_arr[2] = 5; z_arr[2] = 7; end
      model_expect(); #1;
      checks++; if ({req_ready, resp_valid, busy} !== {e_ready, e_rv, e_busy}) begin fails++;
        $display("FAIL single_ctrl cyc=%0d ready=%b/%b rv=%b/%b busy=%b/%b", cyc, req_ready, e_ready, resp_valid, e_rv, busy, e_busy); end
      checks++; if ({unit_x, unit_y, unit_z} !== {e_ux, e_uy, e_uz}) begin fails++;
        $display("FAIL single_unit cyc=%0d got=%h %h %h exp=%h %h %h", cyc, unit_x, unit_y, unit_z, e_ux, e_uy, e_uz); end
      if (c == 0) begin checks++; if (req_ready !== 4'b0100) begin fails++;
        $display("FAIL single_grant got=%b exp=0100", req_ready); end end
      if (resp_valid && first_c < 0) begin
        first_c = c;
        checks++; if ({resp_id, resp_data} !== {2'd2, 32'd22}) begin fails++;
          $display("FAIL single_resp got=%0d:%0d exp=2:22", resp_id, resp_data); end
      end
      model_clock();
    end
    checks++; if (first_c !== 4) begin fails++;
      $display("FAIL single_latency got=%0d exp=4", first_c); end
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL single_busy_fall got=%b exp=0", busy); end
  endtask

  task automatic test_fairness();
    int n_issue = 0;
    for (int c = 0; c < 55; c++) begin
      set_idle();
      if (c < 40) req_valid = 4'b1111;
      model_expect(); #1;
      checks++; if ({req_ready, resp_valid, busy} !== {e_ready, e_rv, e_busy}) begin fails++;
        $display("FAIL fair_ctrl cyc=%0d ready=%b/%b rv=%b/%b busy=%b/%b", cyc, req_ready, e_ready, resp_valid, e_rv, busy, e_busy); end
      checks++; if ({unit_x, unit_y, unit_z} !== {e_ux, e_uy, e_uz}) begin fails++;
        $display("FAIL fair_unit cyc=%0d got=%h %h %h exp=%h %h %h", cyc, unit_x, unit_y, unit_z, e_ux, e_uy, e_uz); end
      if (e_rv) begin checks++; if ({resp_id, resp_data} !== {e_id, e_data}) begin fails++;
        $display("FAIL fair_resp cyc=%0d got=%0d:%h exp=%0d:%h", cyc, resp_id, resp_data, e_id, e_data); end end
      if ((req_ready & req_valid) != '0) n_issue++;
      model_clock();
    end
    checks++; if (n_issue !== 40) begin fails++;
      $display("FAIL fair_throughput got=%0d issues exp=40", n_issue); end
  endtask

  task automatic test_backpressure();
    int n_issue = 0;
    for (int c = 0; c < 50; c++) begin
      set_idle();
      if (c < 34) req_valid = 4'b1111;
      resp_ready = (c >= 14);
      model_expect(); #1;
      checks++; if ({req_ready, resp_valid, busy} !== {e_ready, e_rv, e_busy}) begin fails++;
        $display("FAIL bp_ctrl cyc=%0d ready=%b/%b rv=%b/%b busy=%b/%b", cyc, req_ready, e_ready, resp_valid, e_rv, busy, e_busy); end
      checks++; if ({unit_x, unit_y, unit_z} !== {e_ux, e_uy, e_uz}) begin fails++;
        $display("FAIL bp_unit cyc=%0d got=%h %h %h exp=%h %h %h", cyc, unit_x, unit_y, unit_z, e_ux, e_uy, e_uz); end
      if (e_rv) begin checks++; if ({resp_id, resp_data} !== {e_id, e_data}) begin fails++;
        $display("FAIL bp_resp cyc=%0d got=%0d:%h exp=%0d:%h", cyc, resp_id, resp_data, e_id, e_data); end end
      if (c < 14 && (req_ready & req_valid) != '0) n_issue++;
      if (c == 13) begin checks++; if ({n_issue, req_ready, busy} !== {32'd8, 4'b0000, 1'b1}) begin fails++;
        $display("FAIL bp_stall got issues=%0d ready=%b busy=%b exp 8/0000/1", n_issue, req_ready, busy); end end
      model_clock();
    end
  endtask

  task automatic test_toggle();
    int outst = 0, max_outst = 0;
    for (int c = 0; c < 55; c++) begin
      set_idle();
      if (c < 40) begin req_valid = 4'b1111; resp_ready = c[0]; end
      model_expect(); #1;
      checks++; if ({req_ready, resp_valid, busy} !== {e_ready, e_rv, e_busy}) begin fails++;
        $display("FAIL tog_ctrl cyc=%0d ready=%b/%b rv=%b/%b busy=%b/%b", cyc, req_ready, e_ready, resp_valid, e_rv, busy, e_busy); end
      checks++; if ({unit_x, unit_y, unit_z} !== {e_ux, e_uy, e_uz}) begin fails++;
        $display("FAIL tog_unit cyc=%0d got=%h %h %h exp=%h %h %h", cyc, unit_x, unit_y, unit_z, e_ux, e_uy, e_uz); end
      if (e_rv) begin checks++; if ({resp_id, resp_data} !== {e_id, e_data}) begin fails++;
        $display("FAIL tog_resp cyc=%0d got=%0d:%h exp=%0d:%h", cyc, resp_id, resp_data, e_id, e_data); end end
      if ((req_ready & req_valid) != '0) outst++;
      if (resp_valid && resp_ready) outst--;
      if (outst > max_outst) max_outst = outst;
      model_clock();
    end
    checks++; if (max_outst !== DEPTH) begin fails++;
      $display("FAIL tog_credit got max outstanding=%0d exp=%0d", max_outst, DEPTH); end
  endtask

  task automatic test_reset_midflight();
    int n_rv = 0;
    for (int c = 0; c < 28; c++) begin
      set_idle();
      if (c < 3) req_valid = 4'b0010;
      if (c < 6) resp_ready = 1'b0;
      if (c == 5) rst = 1'b1;
      if (c == 14) req_valid = 4'b1111;
      model_expect(); #1;
      checks++; if ({req_ready, resp_valid, busy} !== {e_ready, e_rv, e_busy}) begin fails++;
        $display("FAIL rmid_ctrl cyc=%0d ready=%b/%b rv=%b/%b busy=%b/%b", cyc, req_ready, e_ready, resp_valid, e_rv, busy, e_busy); end
      checks++; if ({unit_x, unit_y, unit_z} !== {e_ux, e_uy, e_uz}) begin fails++;
        $display("FAIL rmid_unit cyc=%0d got=%h %h %h exp=%h %h %h", cyc, unit_x, unit_y, unit_z, e_ux, e_uy, e_uz); end
      if (e_rv) begin checks++; if ({resp_id, resp_data} !== {e_id, e_data}) begin fails++;
        $display("FAIL rmid_resp cyc=%0d got=%0d:%h exp=%0d:%h", cyc, resp_id, resp_data, e_id, e_data); end end
      if (c >= 5 && c < 14 && resp_valid) n_rv++;
      if (c == 14) begin checks++; if (req_ready !== 4'b0001) begin fails++;
        $display("FAIL rmid_grant0 got=%b exp=0001", req_ready); end end
      model_clock();
    end
    checks++; if (n_rv !== 0) begin fails++;
      $display("FAIL rmid_discard got %0d resp_valid cycles exp=0", n_rv); end
  endtask

  task automatic test_wrap();
    int seen = 0;
    for (int c = 0; c < 10; c++) begin
      set_idle();
      if (c == 0) begin req_valid = 4'b1000; x_arr[3] = '1; y_arr[3] = '1; z_arr[3] = '1; end
      model_expect(); #1;
      checks++; if ({req_ready, resp_valid, busy} !== {e_ready, e_rv, e_busy}) begin fails++;
        $display("FAIL wrap_ctrl cyc=%0d ready=%b/%b rv=%b/%b busy=%b/%b", cyc, req_ready, e_ready, resp_valid, e_rv, busy, e_busy); end
      checks++; if ({unit_x, unit_y, unit_z} !== {e_ux, e_uy, e_uz}) begin fails++;
        $display("FAIL wrap_unit cyc=%0d got=%h %h %h exp=%h %h %h", cyc, unit_x, unit_y, unit_z, e_ux, e_uy, e_uz); end
      if (resp_valid && seen == 0) begin
        seen = 1;
        checks++; if ({resp_id, resp_data} !== {2'd3, 32'h0000_0000}) begin fails++;
          $display("FAIL wrap_resp got=%0d:%h exp=3:00000000", resp_id, resp_data); end
      end
      model_clock();
    end
    checks++; if (seen !== 1) begin fails++;
      $display("FAIL wrap_seen got=%0d exp=1", seen); end
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_toggle();
    test_reset_midflight();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
